// File: rtl/nx_indirect_access_dump_engine.sv
// Indirect-access command initiator: walks an entry range and either dumps each
// entry onto a valid/ready stream or fills it with a fixed pattern.
module nx_indirect_access_dump_engine #(
    parameter int unsigned CMND_ADDRESS    = 0,
    parameter int unsigned N_REG_ADDR_BITS = 16,
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_ENTRIES       = 16,
    parameter int unsigned N_TIMER_BITS    = 6,
    localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       mode,
    input  logic [AW-1:0]              base_addr,
    input  logic [AW:0]                num_entries,
    input  logic [N_DATA_BITS-1:0]     fill_pattern,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [2:0]                 err_code,
    output logic [AW:0]                entries_done,
    output logic [N_REG_ADDR_BITS-1:0] reg_addr,
    output logic [3:0]                 cmnd_op,
    output logic [AW-1:0]              cmnd_addr,
    output logic                       wr_stb,
    output logic [N_DATA_BITS-1:0]     wr_dat,
    input  logic [2:0]                 stat_code,
    input  logic [N_DATA_BITS-1:0]     rd_dat,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [AW-1:0]              dump_addr,
    output logic [N_DATA_BITS-1:0]     dump_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, FINISH} state_t;

    localparam logic [2:0]    STAT_OK      = 3'd0;
    localparam logic [2:0]    STAT_BUSY    = 3'd1;
    localparam logic [2:0]    CODE_TIMEOUT = 3'd7;
    localparam logic [AW-1:0] LAST_ADDR    = AW'(N_ENTRIES - 1);

    state_t                  state, state_nx;
    logic                    mode_q;
    logic [AW-1:0]           cur_addr;
    logic [AW:0]             num_q;
    logic [N_DATA_BITS-1:0]  pattern_q;
    logic                    abort_q;
    logic                    first_wait;
    logic [N_TIMER_BITS-1:0] timer;

    logic                    accept, entry_done, capture, err_set, timer_inc;
    logic [2:0]              err_val;
    logic [AW:0]             done_inc;

    assign done_inc = entries_done + (AW+1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        entry_done = 1'b0;
        capture    = 1'b0;
        err_set    = 1'b0;
        err_val    = '0;
        timer_inc  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        wr_stb     = 1'b0;
        reg_addr   = '0;
        cmnd_op    = '0;
        cmnd_addr  = '0;
        wr_dat     = '0;
        dump_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (num_entries == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                wr_stb    = 1'b1;
                reg_addr  = N_REG_ADDR_BITS'(CMND_ADDRESS);
                cmnd_op   = mode_q ? 4'h2 : 4'h1;
                cmnd_addr = cur_addr;
                if (mode_q) wr_dat = pattern_q;
                state_nx  = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                // First WAIT cycle still shows the previous status; skip it.
                if (!first_wait) begin
                    if (stat_code == STAT_BUSY) begin
                        if (timer == '1) begin
                            err_set  = 1'b1;
                            err_val  = CODE_TIMEOUT;
                            state_nx = FINISH;
                        end else begin
                            timer_inc = 1'b1;
                        end
                    end else if (stat_code == STAT_OK) begin
                        if (mode_q) begin
                            entry_done = 1'b1;
                        end else begin
                            capture  = 1'b1;
                            state_nx = PUSH;
                        end
                    end else begin
                        err_set  = 1'b1;
                        err_val  = stat_code;
                        state_nx = FINISH;
                    end
                end
            end
            PUSH: begin
                busy       = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) entry_done = 1'b1;
            end
            FINISH: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (entry_done)
            state_nx = (done_inc == num_q || abort_q || abort) ? FINISH : ISSUE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q       <= 1'b0;
            cur_addr     <= '0;
            num_q        <= '0;
            pattern_q    <= '0;
            abort_q      <= 1'b0;
            first_wait   <= 1'b0;
            timer        <= '0;
            err          <= 1'b0;
            err_code     <= '0;
            entries_done <= '0;
            dump_addr    <= '0;
            dump_data    <= '0;
        end else begin
            if (accept) begin
                mode_q       <= mode;
                cur_addr     <= base_addr;
                num_q        <= num_entries;
                pattern_q    <= fill_pattern;
                abort_q      <= 1'b0;
                err          <= 1'b0;
                err_code     <= '0;
                entries_done <= '0;
            end else if (state != IDLE && abort) begin
                abort_q <= 1'b1;
            end
            if (state == ISSUE) begin
                timer      <= '0;
                first_wait <= 1'b1;
            end
            if (state == WAIT) first_wait <= 1'b0;
            if (timer_inc) timer <= timer + 1'b1;
            if (capture) begin
                dump_addr <= cur_addr;
                dump_data <= rd_dat;
            end
            if (err_set) begin
                err      <= 1'b1;
                err_code <= err_val;
            end
            if (entry_done) begin
                entries_done <= done_inc;
                cur_addr     <= (cur_addr == LAST_ADDR) ? '0 : cur_addr + 1'b1;
            end
        end
    end

endmodule

// File: doc/nx_indirect_access_dump_engine.md
Name: nx_indirect_access_dump_engine

Overview:
- Command initiator for the indirect-access memory debug interface (cmnd_op/cmnd_addr/wr_stb/wr_dat in; stat_code/rd_dat out) exposed by FIFO/RAM wrappers.
- Walks a contiguous entry range and runs in one of two modes. In dump mode it reads each entry and streams {addr,data} out on a valid/ready port. In fill mode it writes a programmable pattern to each entry.
- Sits between the debug CSR block and one memory wrapper.

Parameters:
- CMND_ADDRESS, 0, register address driven on reg_addr while strobing a command.
- N_REG_ADDR_BITS, 16, reg_addr width.
- N_DATA_BITS, 32, entry data width.
- N_ENTRIES, 16, entries in target memory; address width AW = clog2(N_ENTRIES), min 1.
- N_TIMER_BITS, 6, per-command timeout counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- mode  in  1  0=dump, 1=fill; sampled at start.
- base_addr  in  AW  first entry; sampled at start.
- num_entries  in  AW+1  count; 0 = complete immediately with no command issued.
- fill_pattern  in  N_DATA_BITS  fill data; sampled at start.
- abort  in  1  stop after current command completes.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky until next accepted start.
- err_code  out  3  stat_code captured at error, or 3'd7 on timeout.
- entries_done  out  AW+1  completed-entry count.
- reg_addr  out  N_REG_ADDR_BITS  CMND_ADDRESS during wr_stb, else 0.
- cmnd_op  out  4  4'h1=READ, 4'h2=WRITE, 4'h0 otherwise.
- cmnd_addr  out  AW  target entry.
- wr_stb  out  1  one-cycle command strobe.
- wr_dat  out  N_DATA_BITS  fill data on WRITE strobe, else 0.
- stat_code  in  3  3'd0 OK, 3'd1 BUSY, others are errors.
- rd_dat  in  N_DATA_BITS  read data, valid when stat_code returns to OK after a READ.
- dump_valid  out  1  dump stream valid.
- dump_ready  in  1  dump stream ready.
- dump_addr  out  AW  entry address of dump_data.
- dump_data  out  N_DATA_BITS  captured entry data.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- States: IDLE, ISSUE, WAIT, PUSH, FINISH.
- IDLE + start:
  - Latch mode, base_addr, num_entries, fill_pattern; clear err, err_code, entries_done; busy=1.
  - num_entries==0 goes to FINISH, otherwise to ISSUE.
  - start while busy is ignored.
- ISSUE (1 cycle):
  - Drive wr_stb=1, reg_addr=CMND_ADDRESS, cmnd_op, cmnd_addr=cur_addr; wr_dat=fill_pattern in fill mode.
  - Clear the timer; go to WAIT.
- WAIT:
  - Ignore stat_code in the first WAIT cycle (responder latency).
  - From the second cycle on, evaluate in this order:
    - stat_code==BUSY: timer increments.
    - stat_code==OK, dump mode: capture rd_dat into dump_data and cur_addr into dump_addr; go to PUSH.
    - stat_code==OK, fill mode: entry complete.
    - Any other stat_code: err=1, err_code=stat_code, go to FINISH.
    - Timer saturated at all-ones while still BUSY: err=1, err_code=3'd7, go to FINISH.
- PUSH:
  - dump_valid=1; dump_addr and dump_data are held stable until dump_valid && dump_ready.
  - The handshake completes the entry.
  - Valid never drops without ready, even if abort rises.
- Entry complete:
  - entries_done++.
  - cur_addr++, wrapping from N_ENTRIES-1 to 0 (non-power-of-2 safe).
  - If entries_done reaches num_entries, or abort was seen at any time since start, go to FINISH; otherwise go to ISSUE.
- abort:
  - Sticky internal flag while busy.
  - Never truncates an in-flight command or a pending dump beat.
  - Abort without an error does not set err.
- FINISH (1 cycle): done=1, busy=0, return to IDLE.
- Throughput: dump mode is at best 4 cycles/entry with a 1-cycle responder; fill mode is 3 cycles/entry.
- Error handling: the command-issue strobe is only ever one cycle. No retries after an error.
- Async reset mid-operation: return immediately to IDLE with all outputs 0.

Test Plan:
- Fill mode, base=0, num=4, pattern=0xA5A5A5A5, responder BUSY 2 cycles then OK -> 4 wr_stb pulses, cmnd_op=2, addr 0..3, wr_dat=0xA5A5A5A5; done pulse; entries_done=4; err=0.
- Dump mode, base=14, num=4, N_ENTRIES=16, responder returns rd_dat=addr*3 -> beats (14,42),(15,45),(0,0),(1,3); address wraps 15->0.
- Dump with dump_ready low 5 cycles on beat 2 -> dump_valid held, dump_data stable, no new wr_stb until handshake.
- Responder stuck BUSY -> err=1, err_code=7 after 63 counted cycles; done pulses; entries_done unchanged.
- Responder returns stat_code=3'd4 on entry 2 of 5 -> err_code=4, entries_done=2, done; next start clears err.
- abort asserted during WAIT of entry 1 (num=8) -> entry 1 completes, entries_done=2, done, err=0; start pulse while busy ignored; num_entries=0 -> done next cycle, no wr_stb.
